mul_add_row: RTL

Word-serial row engine for the MonPro datapath: streams an NWORDS-word operand A and accumulator T through one `mul_add` instance, computing T' = A·b + T for a single word b, and emits the NWORDS+1 result words. It owns the carry chain (`last_c`) and both stream handshakes.

---
 rtl/mul_add_row_pkg.sv | 14 +
 rtl/mul_add_row_mul_add.sv | 25 ++
 rtl/mul_add_row.sv | 112 +++++++++++
 3 files changed

// File: rtl/mul_add_row_pkg.sv
// Shared definitions for the word-serial MonPro row engine: default sizing
// and the row sequencer state encoding.
package mul_add_row_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NWORDS     = 4096 / DEFAULT_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } row_state_e;

endpackage

// File: rtl/mul_add_row_mul_add.sv
// Single-word multiply-accumulate: {c, s} = x*y + z + last_c.
// The maximum result is exactly 2^(2*DATA_WIDTH)-1, so the carry fits in one word.
module mul_add
  import mul_add_row_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0] z,
  input  logic [DATA_WIDTH-1:0] last_c,
  output logic [DATA_WIDTH-1:0] s,
  output logic [DATA_WIDTH-1:0] c
);

  logic [2*DATA_WIDTH-1:0] full;

  assign full = ({{DATA_WIDTH{1'b0}}, x} * {{DATA_WIDTH{1'b0}}, y})
              + {{DATA_WIDTH{1'b0}}, z}
              + {{DATA_WIDTH{1'b0}}, last_c};

  assign s = full[DATA_WIDTH-1:0];
  assign c = full[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/mul_add_row.sv
// Row engine: streams A and T words through one mul_add, computing A*b + T
// and emitting NWORDS+1 result words through a single output register.
module mul_add_row
  import mul_add_row_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NWORDS     = 4096 / DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_word,
  input  logic [DATA_WIDTH-1:0] t_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_word,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = $clog2(NWORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  row_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] carry_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] ma_s;
  logic [DATA_WIDTH-1:0] ma_c;

  logic out_free;
  logic in_fire;
  logic out_fire;
  logic start_ok;

  // A new row may only begin once the previous final word has left the register.
  assign out_free = !out_valid || out_ready;
  assign out_fire = out_valid && out_ready;
  assign in_ready = (state_q == RUN) && out_free;
  assign in_fire  = in_valid && in_ready;
  assign start_ok = (state_q == IDLE) && start && !out_valid;
  assign busy     = (state_q != IDLE);

  mul_add #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mul_add (
    .x      (a_word),
    .y      (b_q),
    .z      (t_word),
    .last_c (carry_q),
    .s      (ma_s),
    .c      (ma_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (in_fire && (idx_q == LAST_IDX)) state_d = FLUSH;
      FLUSH:   if (out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register loads a sum word on input fire, or the carry word in FLUSH.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q       <= '0;
      carry_q   <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= out_fire && out_last;
      if (start_ok) begin
        b_q     <= b;
        carry_q <= '0;
        idx_q   <= '0;
      end
      if (in_fire) begin
        out_word  <= ma_s;
        out_last  <= 1'b0;
        out_valid <= 1'b1;
        carry_q   <= ma_c;
        idx_q     <= idx_q + IDX_W'(1);
      end else if ((state_q == FLUSH) && out_free) begin
        out_word  <= carry_q;
        out_last  <= 1'b1;
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
